// File: rtl/alu_cmd_sequencer.sv
// Command FIFO feeding a multi-cycle external ALU, with result hold until the consumer accepts.
// Define ALU_SEQ_OPCHECK_EN to drop commands whose op is not one-hot (err pulse) instead of issuing them.
module alu_cmd_sequencer #(
  parameter int DEPTH    = 4,
  parameter int WAIT_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [6:0] cmd_op,
  output logic       alu_on,
  output logic [2:0] alu_in_sel,
  output logic [7:0] alu_num1,
  output logic [7:0] alu_num2,
  output logic [6:0] alu_out_sel,
  input  logic [7:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [6:0] res_op,
  output logic [1:0] state,
  output logic       err
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int WCW = $clog2(WAIT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } state_t;

  // Handshakes: cmd transfers on a rising edge where cmd_valid && cmd_ready;
  // res transfers on a rising edge where res_valid && res_ready.
  state_t          r_state, w_next_state;
  logic [22:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [WCW-1:0]  r_wait_cnt;
  logic            r_alu_on;
  logic [2:0]      r_alu_in_sel;
  logic [7:0]      r_num1, r_num2, r_res_data;
  logic [6:0]      r_out_sel, r_res_op;
  logic            w_push, w_pop, w_issue, w_op_ok, w_wait_last;
  logic [22:0]     w_head;

  assign cmd_ready   = (r_count < CW'(DEPTH));
  assign w_push      = cmd_valid && cmd_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_wait_last = (r_wait_cnt == WCW'(WAIT_CYC - 1));
  assign w_issue     = w_pop && w_op_ok;

`ifdef ALU_SEQ_OPCHECK_EN
  logic r_err;
  assign w_op_ok = (w_head[6:0] != 7'h00) && ((w_head[6:0] & (w_head[6:0] - 7'h01)) == 7'h00);
  assign err     = r_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= w_pop && !w_op_ok;
  end
`else
  assign w_op_ok = 1'b1;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_op, cmd_b, cmd_a};
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  if (w_wait_last) w_next_state = S_RESP;
      S_RESP:  if (res_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ALU controls are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_wait_cnt   <= '0;
      r_alu_on     <= 1'b0;
      r_alu_in_sel <= 3'b000;
      r_num1       <= 8'h00;
      r_num2       <= 8'h00;
      r_out_sel    <= 7'h00;
      r_res_data   <= 8'h00;
      r_res_op     <= 7'h00;
    end else begin
      r_state      <= w_next_state;
      r_alu_on     <= (w_next_state == S_ISSUE) || (w_next_state == S_WAIT);
      r_alu_in_sel <= (w_next_state == S_ISSUE) ? 3'b010 : 3'b100;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_issue) begin
        r_num1    <= w_head[7:0];
        r_num2    <= w_head[15:8];
        r_out_sel <= w_head[22:16];
      end
      if ((r_state == S_WAIT) && !w_wait_last) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                                     r_wait_cnt <= '0;
      if ((r_state == S_WAIT) && w_wait_last) begin
        r_res_data <= alu_out;
        r_res_op   <= r_out_sel;
      end
    end
  end

  assign alu_on      = r_alu_on;
  assign alu_in_sel  = r_alu_in_sel;
  assign alu_num1    = r_num1;
  assign alu_num2    = r_num2;
  assign alu_out_sel = r_out_sel;
  assign res_valid   = (r_state == S_RESP);
  assign res_data    = r_res_data;
  assign res_op      = r_res_op;
  assign state       = r_state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU, queue-based result model, vector table and corner sequences.
// Honours ALU_SEQ_OPCHECK_EN the same way the design does.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = 8'h00, cmd_b = 8'h00;
  logic [6:0] cmd_op = 7'h00;
  logic       alu_on;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1, alu_num2, alu_out;
  logic [6:0] alu_out_sel;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_data;
  logic [6:0] res_op;
  logic [1:0] state;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;
  logic [14:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] op;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[7];

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_on(alu_on), .alu_in_sel(alu_in_sel),
    .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_out_sel(alu_out_sel),
    .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op),
    .state(state), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [6:0] op);
    case (op)
      7'h40:   return a + b;
      7'h20:   return a - b;
      7'h10:   return a & b;
      7'h08:   return a | b;
      7'h04:   return a ^ b;
      7'h02:   return {a[6:0], 1'b0};
      7'h01:   return ~a;
      default: return 8'hEE;
    endcase
  endfunction

  function automatic bit op_legal(input logic [6:0] op);
`ifdef ALU_SEQ_OPCHECK_EN
    return $countones(op) == 1;
`else
    return 1'b1;
`endif
  endfunction

  // ALU stand-in: captures operands on load, drives a result only while persisting.
  logic [7:0] alu_la = 8'h00, alu_lb = 8'h00;
  logic [6:0] alu_lop = 7'h00;
  always @(posedge clk) begin
    if (alu_on && alu_in_sel == 3'b010) begin
      alu_la  <= alu_num1;
      alu_lb  <= alu_num2;
      alu_lop <= alu_out_sel;
    end
  end
  assign alu_out = (alu_on && alu_in_sel == 3'b100) ? alu_fn(alu_la, alu_lb, alu_lop) : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got data %0h op %0h expected none", res_data, res_op);
      end else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        check("res_data", {24'h0, res_data}, {24'h0, e[7:0]});
        check("res_op", {25'h0, res_op}, {25'h0, e[14:8]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [6:0] op, input logic [7:0] exp);
    int guard = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    while (!cmd_ready && guard < 300) begin
      tick();
      guard++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout: got cmd_ready 0 expected 1");
      cmd_valid = 1'b0;
      return;
    end
    tick();
    cmd_valid = 1'b0;
    if (op_legal(op)) exp_q.push_back({op, exp});
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || state != 2'b00) && g < 1000) begin
      tick();
      g++;
    end
    repeat (3) tick();
    check("drain_pending", exp_q.size(), 0);
  endtask

  int err_cycles;
  int issue_cycles;
  bit rand_done;

  initial begin
    vecs[0] = '{8'h57, 8'h1A, 7'h40, 8'h71};
    vecs[1] = '{8'h10, 8'h20, 7'h20, 8'hF0};
    vecs[2] = '{8'hF0, 8'h3C, 7'h10, 8'h30};
    vecs[3] = '{8'hF0, 8'h0F, 7'h08, 8'hFF};
    vecs[4] = '{8'hAA, 8'hFF, 7'h04, 8'h55};
    vecs[5] = '{8'h81, 8'h00, 7'h02, 8'h02};
    vecs[6] = '{8'h00, 8'h5A, 7'h01, 8'hFF};

    // Reset values while rst is held low
    #2;
    check("rst_state", state, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_op", res_op, 0);
    check("rst_alu_on", alu_on, 0);
    check("rst_alu_in_sel", alu_in_sel, 3'b000);
    check("rst_alu_nums", {alu_num1, alu_num2}, 0);
    check("rst_alu_out_sel", alu_out_sel, 0);
    check("rst_err", err, 0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_in_sel", alu_in_sel, 3'b100);
    check("post_rst_state", state, 0);

    // Single command with exact latency
    res_ready = 1'b0;
    push_cmd(8'h57, 8'h1A, 7'h40, 8'h71);
    check("lat_idle", state, 2'b00);
    tick();
    check("lat_issue_state", state, 2'b01);
    check("lat_issue_sel", alu_in_sel, 3'b010);
    check("lat_issue_on", alu_on, 1);
    check("lat_issue_ops", {alu_num1, alu_num2, 1'b0, alu_out_sel}, {8'h57, 8'h1A, 8'h40});
    tick();
    check("lat_wait_state", state, 2'b10);
    check("lat_wait_sel", alu_in_sel, 3'b100);
    tick();
    check("lat_wait_novalid", res_valid, 0);
    tick();
    check("lat_resp_valid", res_valid, 1);
    check("lat_resp_data", res_data, 8'h71);
    check("lat_resp_op", res_op, 7'h40);
    res_ready = 1'b1;
    tick();
    check("lat_after_accept_valid", res_valid, 0);
    check("lat_after_accept_state", state, 2'b00);
    check("lat_idle_alu_on", alu_on, 0);

    // Vector table
    for (int i = 0; i < 7; i++) push_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
    wait_drain();

    // Fill: five back-to-back with result held
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] a, b;
      logic [6:0] op;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      op = 7'h40 >> i;
      push_cmd(a, b, op, alu_fn(a, b, op));
    end
    check("fill_ready_low", cmd_ready, 0);
    tick();
    check("fill_ready_still_low", cmd_ready, 0);
    res_ready = 1'b1;
    wait_drain();

    // Backpressure in RESP
    res_ready = 1'b0;
    push_cmd(8'h33, 8'h11, 7'h20, 8'h22);
    push_cmd(8'h0F, 8'h01, 7'h40, 8'h10);
    begin
      int g = 0;
      while (!res_valid && g < 50) begin tick(); g++; end
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", res_valid, 1);
      check("bp_data", res_data, exp_q[0][7:0]);
      check("bp_no_issue", alu_in_sel, 3'b100);
      tick();
    end
    res_ready = 1'b1;
    wait_drain();

    // Reset during WAIT with a second command queued
    push_cmd(8'h12, 8'h34, 7'h40, 8'h46);
    push_cmd(8'h56, 8'h78, 7'h10, 8'h50);
    tick();
    check("mid_wait_state", state, 2'b10);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mrst_state", state, 0);
    check("mrst_res_valid", res_valid, 0);
    check("mrst_cmd_ready", cmd_ready, 1);
    check("mrst_alu_on", alu_on, 0);
    tick();
    rst = 1'b1;
    repeat (15) tick();
    check("mrst_quiet_state", state, 0);
    check("mrst_quiet_valid", res_valid, 0);

    // Non-one-hot op
    err_cycles = 0;
    issue_cycles = 0;
    push_cmd(8'h21, 8'h12, 7'b0000011, alu_fn(8'h21, 8'h12, 7'b0000011));
    for (int i = 0; i < 10; i++) begin
      if (err) err_cycles++;
      if (alu_in_sel == 3'b010) issue_cycles++;
      tick();
    end
`ifdef ALU_SEQ_OPCHECK_EN
    check("illegal_err_pulse", err_cycles, 1);
    check("illegal_no_issue", issue_cycles, 0);
`else
    check("illegal_err_zero", err_cycles, 0);
    check("illegal_issued", issue_cycles, 1);
`endif
    wait_drain();
    push_cmd(8'h05, 8'h06, 7'h04, 8'h03);
    wait_drain();

    // Pointer wrap with cycling ops
    for (int i = 0; i < 12; i++) begin
      logic [7:0] a, b;
      logic [6:0] op;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      op = 7'h40 >> (i % 7);
      push_cmd(a, b, op, alu_fn(a, b, op));
    end
    wait_drain();

    // Random traffic with random consumer stalls
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [7:0] a, b;
          logic [6:0] op;
          a = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127));
          else op = 7'h01 << $urandom_range(0, 6);
          push_cmd(a, b, op, alu_fn(a, b, op));
          repeat ($urandom_range(0, 3)) tick();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          res_ready = ($urandom_range(0, 2) != 0);
          tick();
        end
      end
    join
    res_ready = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter WAIT_CYC, default 2, ALU settle cycles before result capture (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  FIFO can accept.
REQ-007 cmd_a  input  8  operand 1.
REQ-008 cmd_b  input  8  operand 2.
REQ-009 cmd_op  input  7  one-hot operation select.
REQ-010 alu_on  output  1  ALU enable.
REQ-011 alu_in_sel  output  3  {persist, load, reset} to ALU.
REQ-012 alu_num1 / alu_num2  output  8 each  operands to ALU.
REQ-013 alu_out_sel  output  7  operation to ALU.
REQ-014 alu_out  input  8  ALU result.
REQ-015 res_valid  output  1  result held.
REQ-016 res_ready  input  1  consumer accepts result.
REQ-017 res_data  output  8  captured result; res_op  output  7  its operation.
REQ-018 state  output  2  current FSM state.
REQ-019 err  output  1  one-cycle illegal-op pulse.

Function
REQ-020 FIFO: push on cmd_valid && cmd_ready; cmd_ready = (count < DEPTH); full blocks push even if a pop occurs in the same cycle.
REQ-021 FIFO order strictly first-in first-out; pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-022 FSM states: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11.
REQ-023 IDLE: if FIFO non-empty, pop head into operand/op registers, next state ISSUE; else stay.
REQ-024 ISSUE (one cycle): alu_on=1, alu_in_sel=3'b010, alu_num1/num2/out_sel = registered command; next WAIT.
REQ-025 WAIT: alu_on=1, alu_in_sel=3'b100, operands/op held; counts WAIT_CYC cycles; on last cycle res_data<=alu_out, res_op<=op; next RESP.
REQ-026 RESP: res_valid=1, res_data/res_op stable; on res_ready go IDLE; res_valid low next cycle.
REQ-027 IDLE outputs: alu_on=0, alu_in_sel=3'b100, alu_num1/num2/out_sel hold last values.
REQ-028 Latency: head present in IDLE at cycle t -> res_valid asserted at t+2+WAIT_CYC; with res_ready held high, throughput one command per 3+WAIT_CYC cycles.
REQ-029 Pushes continue in any state; pops occur only in IDLE.
REQ-030 err is 0 except as in REQ-034.

Reset
REQ-031 rst low: immediately state=IDLE, FIFO empty (count 0, pointers 0), cmd_ready=1, res_valid=0, res_data=8'h00, res_op=7'h00, alu_on=0, alu_in_sel=3'b000, alu_num1/num2=8'h00, alu_out_sel=7'h00, err=0, wait counter 0.
REQ-032 Reset mid-operation abandons the in-flight command and all queued commands; no result emitted.
REQ-033 After rst rises, first rising edge resumes normal IDLE operation (alu_in_sel=3'b100).

Configuration
REQ-034 ALU_SEQ_OPCHECK_EN defined: in IDLE a popped op not exactly one-hot (including 7'h00) is dropped, err pulses one cycle, FSM stays IDLE, no ALU issue.
REQ-035 ALU_SEQ_OPCHECK_EN undefined: every op issued unchecked; err tied 0.

Verification
REQ-036 Single op: push a=8'h57, b=8'h1A, op=7'b1000000 (model add) -> alu_in_sel 3'b010 one cycle, res_valid at t+4 (WAIT_CYC=2), res_data=8'h71, res_op=7'b1000000.
REQ-037 Fill: push 5 commands back-to-back with res_ready=0 -> cmd_ready low after count reaches 4 (one popped, so 5th accepted once ISSUE begins); results emerge in push order.
REQ-038 Backpressure: res_ready=0 for 10 cycles in RESP -> res_valid and res_data stable, no new ISSUE until accept.
REQ-039 Reset mid-WAIT: rst low for one cycle -> res_valid=0, cmd_ready=1, state=2'b00, no result for abandoned command.
REQ-040 Illegal op 7'b0000011 with ALU_SEQ_OPCHECK_EN -> err=1 one cycle, no alu_in_sel=3'b010, next valid command processed normally; without macro -> issued, err stays 0.
REQ-041 Wrap: 12 sequential commands, ops cycling 7'b1000000..7'b0000001 -> all results correct and ordered across pointer wrap.
